// File: rtl/myproject_mac_pkg.sv
// Shared constants, beat-control payload and saturation bound helpers for the MAC pipe.
`timescale 1ns/1ps
package myproject_mac_pkg;

    localparam int unsigned DEF_DIN0_WIDTH = 10;
    localparam int unsigned DEF_DIN1_WIDTH = 8;
    localparam int unsigned DEF_DOUT_WIDTH = 17;
    localparam int unsigned DEF_ACC_WIDTH  = 24;
    localparam int unsigned DEF_NUM_STAGE  = 2;
    localparam int unsigned MAX_ACC_WIDTH  = 64;

    typedef logic [MAX_ACC_WIDTH-1:0] bound_t;

    // Accumulation framing flags carried alongside each product.
    typedef struct packed {
        logic first;
        logic last;
    } acc_ctl_t;

    // Largest representable result for a dw-bit output (two's complement pattern).
    function automatic bound_t sat_max(input int unsigned dw, input bit sgn);
        if (sgn) begin
            return (bound_t'(1) << (dw - 1)) - bound_t'(1);
        end
        return (bound_t'(1) << dw) - bound_t'(1);
    endfunction

    // Smallest representable result for a dw-bit output (two's complement pattern).
    function automatic bound_t sat_min(input int unsigned dw, input bit sgn);
        if (sgn) begin
            return ~((bound_t'(1) << (dw - 1)) - bound_t'(1));
        end
        return '0;
    endfunction

endpackage

// File: rtl/myproject_mul_pipe.sv
// Operand extension, exact multiply and an enable-gated NUM_STAGE register chain.
`timescale 1ns/1ps
module myproject_mul_pipe
    import myproject_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH  = DEF_DIN0_WIDTH,
    parameter int unsigned DIN1_WIDTH  = DEF_DIN1_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned NUM_STAGE   = DEF_NUM_STAGE,
    parameter int unsigned SIGNED_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  acc_ctl_t              in_ctl,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_prod,
    output acc_ctl_t              out_ctl
);

    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] prod_c;

    logic                 stg_valid [NUM_STAGE];
    logic [ACC_WIDTH-1:0] stg_prod  [NUM_STAGE];
    acc_ctl_t             stg_ctl   [NUM_STAGE];

    // Widen operands to the accumulator width; the low ACC_WIDTH bits of the product are exact.
    always_comb begin
        if (SIGNED_MODE != 0) begin
            a_ext = ACC_WIDTH'($signed(din0));
            b_ext = ACC_WIDTH'($signed(din1));
        end else begin
            a_ext = ACC_WIDTH'(din0);
            b_ext = ACC_WIDTH'(din1);
        end
        prod_c = a_ext * b_ext;
    end

    // Stage chain: every stage shifts together on en, bubbles travel as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_valid[i] <= 1'b0;
                stg_prod[i]  <= '0;
                stg_ctl[i]   <= '0;
            end
        end else if (en) begin
            stg_valid[0] <= in_valid;
            stg_prod[0]  <= prod_c;
            stg_ctl[0]   <= in_ctl;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_prod[i]  <= stg_prod[i-1];
                stg_ctl[i]   <= stg_ctl[i-1];
            end
        end
    end

    assign out_valid = stg_valid[NUM_STAGE-1];
    assign out_prod  = stg_prod[NUM_STAGE-1];
    assign out_ctl   = stg_ctl[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate with framed accumulation, saturation and a stallable result register.
`timescale 1ns/1ps
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int unsigned DIN0_WIDTH  = DEF_DIN0_WIDTH,
    parameter int unsigned DIN1_WIDTH  = DEF_DIN1_WIDTH,
    parameter int unsigned DOUT_WIDTH  = DEF_DOUT_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned NUM_STAGE   = DEF_NUM_STAGE,
    parameter int unsigned SIGNED_MODE = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_first,
    input  logic                  acc_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_sat
);

    localparam logic [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(DOUT_WIDTH, SIGNED_MODE != 0));
    localparam logic [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(DOUT_WIDTH, SIGNED_MODE != 0));

    logic                 en;
    acc_ctl_t             in_ctl;
    logic                 p_valid;
    logic [ACC_WIDTH-1:0] p_prod;
    acc_ctl_t             p_ctl;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [ACC_WIDTH-1:0] sat_val;
    logic                 sat_hit;

    // Whole datapath advances only while the result register can take a new value.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign in_ctl   = '{first: acc_first, last: acc_last};

    myproject_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .NUM_STAGE  (NUM_STAGE),
        .SIGNED_MODE(SIGNED_MODE)
    ) u_mul_pipe (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .en       (en),
        .in_valid (in_valid),
        .din0     (din0),
        .din1     (din1),
        .in_ctl   (in_ctl),
        .out_valid(p_valid),
        .out_prod (p_prod),
        .out_ctl  (p_ctl)
    );

    // Next accumulator value and its clipped image in the output range.
    always_comb begin
        acc_next = p_ctl.first ? p_prod : acc + p_prod;
        sat_val  = acc_next;
        sat_hit  = 1'b0;
        if (SIGNED_MODE != 0) begin
            if ($signed(acc_next) > $signed(SAT_HI)) begin
                sat_val = SAT_HI;
                sat_hit = 1'b1;
            end else if ($signed(acc_next) < $signed(SAT_LO)) begin
                sat_val = SAT_LO;
                sat_hit = 1'b1;
            end
        end else if (acc_next > SAT_HI) begin
            sat_val = SAT_HI;
            sat_hit = 1'b1;
        end
    end

    // Accumulator folds in each valid product leaving the multiplier pipe.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
        end else if (en && p_valid) begin
            acc <= acc_next;
        end
    end

    // Result register: loads on a closing beat, otherwise empties once consumed.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_sat  <= 1'b0;
        end else if (en) begin
            if (p_valid && p_ctl.last) begin
                out_valid <= 1'b1;
                dout      <= DOUT_WIDTH'(sat_val);
                dout_sat  <= sat_hit;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Drives an unsigned and a signed MAC with identical beats and scoreboards both results.
`timescale 1ns/1ps
module tb_myproject_mac_pipe;

    localparam int NUM_STAGE = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  din0;
    logic [7:0]  din1;
    logic        acc_first;
    logic        acc_last;
    logic        out_ready;
    logic        in_ready_u, in_ready_s;
    logic        out_valid_u, out_valid_s;
    logic [16:0] dout_u, dout_s;
    logic        sat_u, sat_s;

    int cyc;
    int n_checks;
    int n_errors;
    int last_acc;

    typedef struct {
        logic [9:0]  d0;
        logic [7:0]  d1;
        logic [16:0] eu;
        logic        su;
        logic [16:0] es;
        logic        ss;
    } vec_t;

    typedef struct {
        logic [16:0] eu;
        logic        su;
        logic [16:0] es;
        logic        ss;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    vec_t vecs [8];
    exp_t q [$];

    myproject_mac_pipe #(
        .DIN0_WIDTH(10), .DIN1_WIDTH(8), .DOUT_WIDTH(17), .ACC_WIDTH(24),
        .NUM_STAGE(NUM_STAGE), .SIGNED_MODE(0)
    ) u_dut_u (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid_u), .out_ready(out_ready), .dout(dout_u), .dout_sat(sat_u)
    );

    myproject_mac_pipe #(
        .DIN0_WIDTH(10), .DIN1_WIDTH(8), .DOUT_WIDTH(17), .ACC_WIDTH(24),
        .NUM_STAGE(NUM_STAGE), .SIGNED_MODE(1)
    ) u_dut_s (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .dout_sat(sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one beat, wait (bounded) for acceptance, then withdraw it.
    task automatic send(input logic [9:0] a, input logic [7:0] b, input logic f, input logic l);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1; din0 = a; din1 = b; acc_first = f; acc_last = l;
        while (!in_ready_u && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("send_timeout_in_ready", 32'(in_ready_u), 32'd1);
        last_acc = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [16:0] eu, input logic su,
                              input logic [16:0] es, input logic ss, input bit lat);
        exp_t e;
        e.eu = eu; e.su = su; e.es = es; e.ss = ss; e.acc_cyc = last_acc; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_acc = 0;
        rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
        acc_first = 1'b0; acc_last = 1'b0; out_ready = 1'b1;

        //                 d0      d1     unsigned exp       signed exp
        vecs[0] = '{10'd1023, 8'd255, 17'd131071, 1'b1, 17'd1,      1'b0};
        vecs[1] = '{10'h3FD,  8'd5,   17'd5105,   1'b0, 17'h1FFF1,  1'b0};
        vecs[2] = '{10'd0,    8'd0,   17'd0,      1'b0, 17'd0,      1'b0};
        vecs[3] = '{10'h200,  8'h80,  17'd65536,  1'b0, 17'h0FFFF,  1'b1};
        vecs[4] = '{10'h1FF,  8'h80,  17'd65408,  1'b0, 17'h10080,  1'b0};
        vecs[5] = '{10'h1FF,  8'h7F,  17'd64897,  1'b0, 17'd64897,  1'b0};
        vecs[6] = '{10'h200,  8'h7F,  17'd65024,  1'b0, 17'h10200,  1'b0};
        vecs[7] = '{10'd1023, 8'h80,  17'd130944, 1'b0, 17'd128,    1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid_u", 32'(out_valid_u), 32'd0);
        chk("reset_out_valid_s", 32'(out_valid_s), 32'd0);
        chk("reset_in_ready",    32'(in_ready_u),  32'd1);
        chk("reset_dout_u",      32'(dout_u),      32'd0);
        chk("reset_sat_u",       32'(sat_u),       32'd0);
        rst_n = 1'b1;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && out_valid_u && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", 32'(out_valid_u), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("dout_u",      32'(dout_u),      32'(e.eu));
                        chk("sat_u",       32'(sat_u),       32'(e.su));
                        chk("out_valid_s", 32'(out_valid_s), 32'd1);
                        chk("dout_s",      32'(dout_s),      32'(e.es));
                        chk("sat_s",       32'(sat_s),       32'(e.ss));
                        if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'(NUM_STAGE));
                    end
                end
            end
        join_none

        // First beat after reset without acc_first accumulates onto zero.
        send(10'd4, 8'd5, 1'b0, 1'b1);
        expect_res(17'd20, 1'b0, 17'd20, 1'b0, 1'b1);

        // Back-to-back single-beat results.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].d0, vecs[i].d1, 1'b1, 1'b1);
            expect_res(vecs[i].eu, vecs[i].su, vecs[i].es, vecs[i].ss, 1'b1);
        end
        drain();

        // Four-beat accumulation: 4 * (2*3).
        send(10'd2, 8'd3, 1'b1, 1'b0);
        send(10'd2, 8'd3, 1'b0, 1'b0);
        send(10'd2, 8'd3, 1'b0, 1'b0);
        send(10'd2, 8'd3, 1'b0, 1'b1);
        expect_res(17'd24, 1'b0, 17'd24, 1'b0, 1'b1);

        // Signed sum below the negative bound: 2 * (-512*127).
        send(10'h200, 8'h7F, 1'b1, 1'b0);
        send(10'h200, 8'h7F, 1'b0, 1'b1);
        expect_res(17'h1FC00, 1'b0, 17'h10000, 1'b1, 1'b1);

        // Unsigned sum landing exactly on the maximum.
        send(10'd1023, 8'd127, 1'b1, 1'b0);
        send(10'd115,  8'd10,  1'b0, 1'b1);
        expect_res(17'h1FFFF, 1'b0, 17'd1023, 1'b0, 1'b1);

        // Unsigned sum one above the maximum.
        send(10'd1023, 8'd127, 1'b1, 1'b0);
        send(10'd1000, 8'd1,   1'b0, 1'b0);
        send(10'd151,  8'd1,   1'b0, 1'b1);
        expect_res(17'h1FFFF, 1'b1, 17'd0, 1'b0, 1'b1);
        drain();

        // Consumer stall: result held, input blocked, queued result follows on release.
        out_ready = 1'b0;
        send(10'd100, 8'd2, 1'b1, 1'b1);
        expect_res(17'd200, 1'b0, 17'd200, 1'b0, 1'b0);
        send(10'd5, 8'd5, 1'b1, 1'b1);
        expect_res(17'd25, 1'b0, 17'd25, 1'b0, 1'b0);
        begin
            int w;
            w = 0;
            while (!out_valid_u && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("stall_out_valid", 32'(out_valid_u), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(in_ready_u),  32'd0);
            chk("stall_out_valid", 32'(out_valid_u), 32'd1);
            chk("stall_dout_u",    32'(dout_u),      32'd200);
            chk("stall_sat_u",     32'(sat_u),       32'd0);
            chk("stall_dout_s",    32'(dout_s),      32'd200);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset with a pending result and a half-built accumulation.
        send(10'd7, 8'd7, 1'b1, 1'b1);
        send(10'd2, 8'd3, 1'b1, 1'b0);
        send(10'd2, 8'd3, 1'b0, 1'b0);
        chk("pre_reset_out_valid", 32'(out_valid_u), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid_u", 32'(out_valid_u), 32'd0);
        chk("rst_out_valid_s", 32'(out_valid_s), 32'd0);
        chk("rst_in_ready",    32'(in_ready_u),  32'd1);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(10'd3, 8'd3, 1'b0, 1'b1);
        expect_res(17'd9, 1'b0, 17'd9, 1'b0, 1'b1);
        send(10'd7, 8'd9, 1'b1, 1'b1);
        expect_res(17'd63, 1'b0, 17'd63, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
